seq_detect_prog: RTL and testbench

//  Programmable serial pattern detector for button/bit streams. Runtime-loadable pattern (1..PAT_W bits),

---
 rtl/seq_detect_prog.sv | 124 ++++++++++++
 tb/tb_seq_detect_prog.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with runtime-loadable pattern,
// overlap mode, input qualifier and saturating match counter.
module seq_detect_prog #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 'b1010,
  parameter int DEF_LEN = 4,
  parameter bit DEF_OVERLAP = 1'b1,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  input  logic             i_cfg_load,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_pat_len,
  input  logic             i_overlap,
  input  logic             i_cnt_clr,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_cfg_err
);

  localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic             r_cfg_err;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_match;
  logic [CNT_W-1:0] r_cnt;

  logic [PAT_W-1:0] w_hist_new;
  logic [LEN_W-1:0] w_fill_new;
  logic [PAT_W-1:0] w_mask;
  logic             w_len_bad;
  logic             w_load_bad;
  logic             w_accept;
  logic             w_match;

  assign w_hist_new = {r_hist[PAT_W-2:0], i_bit};
  assign w_fill_new = (r_fill == FULL) ? r_fill : r_fill + 1'b1;
  assign w_len_bad  = (r_len == '0) || (r_len > FULL);
  assign w_load_bad = (i_pat_len == '0) || (i_pat_len > FULL);
  assign w_accept   = i_bit_valid && !i_cfg_load;

  // Select only the low len bits of history/pattern for the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  assign w_match = w_accept && !w_len_bad
                && (w_fill_new >= r_len)
                && (((w_hist_new ^ r_pattern) & w_mask) == '0);

  // Active configuration, replaced on a load strobe.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= DEF_LEN_L;
      r_overlap <= DEF_OVERLAP;
    end else if (i_cfg_load) begin
      r_pattern <= i_pattern;
      r_len     <= i_pat_len;
      r_overlap <= i_overlap;
    end
  end

  // Registered legality flag of the active pattern length.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cfg_err <= 1'b0;
    end else if (i_cfg_load) begin
      r_cfg_err <= w_load_bad;
    end
  end

  // Bit history and fill level; non-overlap mode restarts fill on a hit.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_cfg_load) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_bit_valid) begin
      r_hist <= w_hist_new;
      r_fill <= (w_match && !r_overlap) ? '0 : w_fill_new;
    end
  end

  // One-cycle match pulse following the accepting edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_match <= 1'b0;
    end else begin
      r_match <= w_match;
    end
  end

  // Saturating match counter; clear has priority over an increment.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_match     = r_match;
  assign o_match_cnt = r_cnt;
  assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: vector table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_seq_detect_prog;

  logic        i_clock;
  logic        i_reset;
  logic        i_bit_valid;
  logic        i_bit;
  logic        i_cfg_load;
  logic [7:0]  i_pattern;
  logic [3:0]  i_pat_len;
  logic        i_overlap;
  logic        i_cnt_clr;
  logic        o_match;
  logic [15:0] o_match_cnt;
  logic        o_cfg_err;
  logic        o_match2;
  logic [1:0]  o_match_cnt2;
  logic        o_cfg_err2;

  int checks = 0;
  int failures = 0;

  seq_detect_prog u_dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_bit_valid(i_bit_valid), .i_bit(i_bit),
    .i_cfg_load(i_cfg_load), .i_pattern(i_pattern),
    .i_pat_len(i_pat_len), .i_overlap(i_overlap),
    .i_cnt_clr(i_cnt_clr), .o_match(o_match),
    .o_match_cnt(o_match_cnt), .o_cfg_err(o_cfg_err)
  );

  seq_detect_prog #(.CNT_W(2)) u_dut2 (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_bit_valid(i_bit_valid), .i_bit(i_bit),
    .i_cfg_load(i_cfg_load), .i_pattern(i_pattern),
    .i_pat_len(i_pat_len), .i_overlap(i_overlap),
    .i_cnt_clr(i_cnt_clr), .o_match(o_match2),
    .o_match_cnt(o_match_cnt2), .o_cfg_err(o_cfg_err2)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // ---------------- reference model ----------------
  bit       mq[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ov;
  bit       m_err;
  bit       m_match;
  int       m_cnt;
  int       m_cnt2;

  function automatic void model_reset();
    mq.delete();
    m_pat = 8'b1010;
    m_len = 4;
    m_ov = 1'b1;
    m_err = 1'b0;
    m_match = 1'b0;
    m_cnt = 0;
    m_cnt2 = 0;
  endfunction

  function automatic bit tail_hits();
    if (m_err || mq.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (mq[mq.size() - 1 - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_step(
    input bit ld, input bit [7:0] pat, input bit [3:0] len,
    input bit ov, input bit vld, input bit b, input bit clr
  );
    bit hit;
    hit = 1'b0;
    if (ld) begin
      m_pat = pat;
      m_len = int'(len);
      m_ov = ov;
      m_err = (len == 0) || (len > 8);
      mq.delete();
    end else if (vld) begin
      mq.push_back(b);
      if (mq.size() > 8) void'(mq.pop_front());
      hit = tail_hits();
      if (hit && !m_ov) mq.delete();
    end
    m_match = hit;
    if (clr) begin
      m_cnt = 0;
      m_cnt2 = 0;
    end else if (hit) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(
    input logic ld, input logic [7:0] pat, input logic [3:0] len,
    input logic ov, input logic vld, input logic b, input logic clr
  );
    i_cfg_load = ld;
    i_pattern = pat;
    i_pat_len = len;
    i_overlap = ov;
    i_bit_valid = vld;
    i_bit = b;
    i_cnt_clr = clr;
    @(posedge i_clock);
    #1;
    model_step(ld, pat, len, ov, vld, b, clr);
    i_cfg_load = 1'b0;
    i_bit_valid = 1'b0;
    i_cnt_clr = 1'b0;
  endtask

  task automatic feed(input logic vld, input logic b);
    step(1'b0, 8'h00, 4'd0, 1'b0, vld, b, 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len,
                      input logic ov, input logic clr);
    step(1'b1, pat, len, ov, 1'b0, 1'b0, clr);
  endtask

  // Asserts reset between clock edges and checks outputs without an edge.
  task automatic do_reset(input string nm);
    i_cfg_load = 1'b0;
    i_bit_valid = 1'b0;
    i_cnt_clr = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    model_reset();
    chk({nm, "_match"}, {31'd0, o_match}, 32'd0);
    chk({nm, "_cnt"}, {16'd0, o_match_cnt}, 32'd0);
    chk({nm, "_err"}, {31'd0, o_cfg_err}, 32'd0);
    chk({nm, "_cnt2"}, {30'd0, o_match_cnt2}, 32'd0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
  endtask

  typedef struct {
    logic        ld;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ov;
    logic        vld;
    logic        b;
    logic        clr;
    logic        e_match;
    logic [15:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic ld, input logic [7:0] pat, input logic [3:0] len,
    input logic ov, input logic vld, input logic b, input logic clr,
    input logic em, input logic [15:0] ec, input logic ee
  );
    vec_t v;
    v.ld = ld; v.pat = pat; v.len = len; v.ov = ov;
    v.vld = vld; v.b = b; v.clr = clr;
    v.e_match = em; v.e_cnt = ec; v.e_err = ee;
    return v;
  endfunction

  initial begin
    logic [7:0] s1;
    logic [15:0] s3;
    logic [1:0] c5;
    logic [7:0] rp;
    logic [3:0] rl;
    int r;

    i_reset = 1'b0;
    i_bit_valid = 1'b0;
    i_bit = 1'b0;
    i_cfg_load = 1'b0;
    i_pattern = 8'h00;
    i_pat_len = 4'd0;
    i_overlap = 1'b0;
    i_cnt_clr = 1'b0;
    model_reset();

    do_reset("rst0");

    // T1 default 1010 overlapping; T2 non-overlapping (load wins over bit).
    s1 = 8'b10101010;
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(0, 0, 0, 0, 1, s1[7-i], 0,
                       (i == 3 || i == 5 || i == 7),
                       16'((i + 1 - 2) / 2), 0));
    end
    tbl.push_back(mk(1, 8'h0A, 4'd4, 0, 1, 1, 1, 0, 16'd0, 0));
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(0, 0, 0, 0, 1, s1[7-i], 0,
                       (i == 3 || i == 7),
                       (i >= 7) ? 16'd2 : (i >= 3) ? 16'd1 : 16'd0,
                       0));
    end
    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ov,
           tbl[i].vld, tbl[i].b, tbl[i].clr);
      chk($sformatf("tbl%0d_match", i), {31'd0, o_match},
          {31'd0, tbl[i].e_match});
      chk($sformatf("tbl%0d_cnt", i), {16'd0, o_match_cnt},
          {16'd0, tbl[i].e_cnt});
      chk($sformatf("tbl%0d_err", i), {31'd0, o_cfg_err},
          {31'd0, tbl[i].e_err});
    end

    // T3 8-bit pattern, valid toggling.
    load(8'b11011101, 4'd8, 1'b1, 1'b1);
    chk("t3_load_cnt", {16'd0, o_match_cnt}, 32'd0);
    s3 = 16'b1101110111011101;
    for (int i = 0; i < 16; i++) begin
      feed(1'b1, s3[15-i]);
      chk($sformatf("t3_bit%0d", i + 1), {31'd0, o_match},
          {31'd0, (i == 7 || i == 11 || i == 15)});
      feed(1'b0, 1'($urandom_range(0, 1)));
      chk($sformatf("t3_idle%0d", i + 1), {31'd0, o_match}, 32'd0);
    end
    chk("t3_cnt", {16'd0, o_match_cnt}, 32'd3);

    // T4 illegal length disables detection.
    load(8'h00, 4'd0, 1'b1, 1'b0);
    chk("t4_err_set", {31'd0, o_cfg_err}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      feed(1'b1, 1'($urandom_range(0, 1)));
      chk($sformatf("t4_nomatch%0d", i), {31'd0, o_match}, 32'd0);
    end
    chk("t4_cnt_hold", {16'd0, o_match_cnt}, 32'd3);
    load(8'b101, 4'd3, 1'b1, 1'b0);
    chk("t4_err_clr", {31'd0, o_cfg_err}, 32'd0);
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b0);
    feed(1'b1, 1'b1);
    chk("t4_len3_match", {31'd0, o_match}, 32'd1);

    // T5 length-1 pattern, 2-bit saturating counter, clear beats match.
    load(8'h01, 4'd1, 1'b0, 1'b1);
    chk("t5_cnt2_clr", {30'd0, o_match_cnt2}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      feed(1'b1, 1'b1);
      c5 = (i < 3) ? 2'(i + 1) : 2'd3;
      chk($sformatf("t5_match%0d", i), {31'd0, o_match2}, 32'd1);
      chk($sformatf("t5_cnt%0d", i), {30'd0, o_match_cnt2},
          {30'd0, c5});
    end
    feed(1'b1, 1'b0);
    chk("t5_zero_bit", {31'd0, o_match2}, 32'd0);
    step(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_clr_match", {31'd0, o_match2}, 32'd1);
    chk("t5_clr_cnt2", {30'd0, o_match_cnt2}, 32'd0);
    chk("t5_clr_cnt", {16'd0, o_match_cnt}, 32'd0);

    // T6 asynchronous reset mid-stream discards history.
    do_reset("t6_rst_a");
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b0);
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b0);
    chk("t6_pre_match", {31'd0, o_match}, 32'd1);
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b0);
    feed(1'b1, 1'b1);
    chk("t6_pre_cnt", {16'd0, o_match_cnt}, 32'd2);
    do_reset("t6_rst_b");
    feed(1'b1, 1'b0);
    chk("t6_no_stale", {31'd0, o_match}, 32'd0);
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b0);
    feed(1'b1, 1'b1);
    chk("t6_no_early", {31'd0, o_match}, 32'd0);
    feed(1'b1, 1'b0);
    chk("t6_match", {31'd0, o_match}, 32'd1);
    chk("t6_cnt", {16'd0, o_match_cnt}, 32'd1);

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        rp = 8'($urandom);
        r = $urandom_range(0, 9);
        if (r == 0) rl = 4'd0;
        else if (r == 9) rl = 4'($urandom_range(9, 15));
        else if (r < 6) rl = 4'($urandom_range(1, 3));
        else rl = 4'($urandom_range(4, 8));
        step(1'b1, rp, rl, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 39) == 0));
      end else begin
        step(1'b0, 8'($urandom), 4'($urandom), 1'($urandom),
             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 39) == 0));
      end
      chk($sformatf("rnd%0d_match", i), {31'd0, o_match},
          {31'd0, m_match});
      chk($sformatf("rnd%0d_cnt", i), {16'd0, o_match_cnt},
          32'(m_cnt));
      chk($sformatf("rnd%0d_err", i), {31'd0, o_cfg_err},
          {31'd0, m_err});
      chk($sformatf("rnd%0d_cnt2", i), {30'd0, o_match_cnt2},
          32'(m_cnt2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
